// File: rtl/bcd_gray_seq_ctrl.sv
// bcd_gray_seq_ctrl
// Converts a packed word of DIGITS nibbles one digit per cycle through a single
// shared 4-bit BCD<->Gray datapath, LSB digit first. It also flags each digit
// whose value is outside the BCD range 0-9.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   in_valid/in_ready   input word handshake (in_data, in_mode)
//   in_mode             0 = BCD->Gray, 1 = Gray->BCD (latched at accept)
//   in_data             packed digits, digit i = bits [4i+3:4i]
//   out_valid/out_ready result handshake (out_data, out_err_mask, out_err)
//   out_data            converted word, same packing as in_data
//   out_err_mask        bit i set = digit i outside 0-9
//   out_err             OR of out_err_mask
//   busy                sequencer not idle
module bcd_gray_seq_ctrl #(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_mode,
   input  logic [4*DIGITS-1:0]   in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_data,
   output logic [DIGITS-1:0]     out_err_mask,
   output logic                  out_err,
   output logic                  busy
);

   localparam int unsigned W     = 4 * DIGITS;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [W-1:0]     word_q;   // captured word, shifted so the active digit sits at [3:0]
   logic             mode_q;
   logic             ready_q;  // registered "state == IDLE"

   logic [3:0]       cur;
   logic [3:0]       conv_nib;
   logic             conv_err;

   // Gated by rst_n so the producer sees no ready while reset is held.
   assign in_ready = ready_q & rst_n;

   // Shared nibble converter: Gray encode (b ^ b>>1) or prefix-XOR Gray decode.
   always_comb begin
      cur      = word_q[3:0];
      conv_nib = '0;
      conv_err = 1'b0;
      if (!mode_q) begin
         conv_nib = {cur[3], cur[3] ^ cur[2], cur[2] ^ cur[1], cur[1] ^ cur[0]};
         conv_err = (cur > 4'd9);
      end else begin
         conv_nib = {cur[3],
                     cur[3] ^ cur[2],
                     cur[3] ^ cur[2] ^ cur[1],
                     cur[3] ^ cur[2] ^ cur[1] ^ cur[0]};
         conv_err = (conv_nib > 4'd9);
      end
   end

   // Sequencer: IDLE accepts a word, CONV walks DIGITS cycles, DONE holds the result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         word_q       <= '0;
         mode_q       <= 1'b0;
         ready_q      <= 1'b1;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_err_mask <= '0;
         out_err      <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && ready_q) begin
                  word_q       <= in_data;
                  mode_q       <= in_mode;
                  out_data     <= '0;
                  out_err_mask <= '0;
                  out_err      <= 1'b0;
                  idx          <= '0;
                  ready_q      <= 1'b0;
                  busy         <= 1'b1;
                  state        <= CONV;
               end
            end
            CONV: begin
               out_data[4*idx +: 4] <= conv_nib;
               out_err_mask[idx]    <= conv_err;
               out_err              <= out_err | conv_err;
               word_q               <= word_q >> 4;
               if (idx == LAST_IDX) begin
                  idx       <= '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  ready_q   <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               ready_q   <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
